// File: rtl/stream_credit_tx_if.sv
// Handshake bundle for stream_credit_tx: upstream i_* stream in, downstream o_* stream out.
// The slave modport is the transmitter's view; master is the environment's view.
interface stream_credit_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] i_d;
    logic             i_v;
    logic             i_r;
    logic [WIDTH-1:0] o_d;
    logic             o_v;
    logic             o_r;

    modport slave (
        input  i_d, i_v, o_r,
        output i_r, o_d, o_v
    );

    modport master (
        output i_d, i_v, o_r,
        input  i_r, o_d, o_v
    );
endinterface

// File: rtl/stream_credit_tx.sv
// Credit-gated stream transmitter: 2-entry skid buffer feeding a FIFO while its occupancy stays below DEPTH-MARGIN.
// Optional beat/stall counters are built when STREAM_CREDIT_TX_STATS_EN is defined.
module stream_credit_tx #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4096,
    parameter int CNT_W  = 12,
    parameter int MARGIN = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [CNT_W-1:0]     fifo_count,
    stream_credit_tx_if.slave    bus,
    output logic                 throttle,
    output logic [31:0]          beat_cnt,
    output logic [31:0]          stall_cnt
);

    localparam logic [CNT_W:0] LIMIT = (CNT_W+1)'(DEPTH - MARGIN);

    typedef struct packed {
        logic             v;
        logic [WIDTH-1:0] d;
    } entry_t;

    entry_t m_q, s_q, m_n, s_n;
    logic   ir_q;
    logic   gate_q;
    logic   xfer;
    logic   accept;

    assign bus.o_d = m_q.d;
    assign bus.o_v = m_q.v & gate_q;
    assign bus.i_r = ir_q;
    assign xfer    = bus.o_v & bus.o_r;
    assign accept  = bus.i_v & ir_q;
    assign throttle = m_q.v & ~gate_q;

    // Skid never accepts while full because i_r mirrors !S.valid.
    always_comb begin
        m_n = m_q;
        s_n = s_q;
        if (xfer) begin
            if (s_q.v) begin
                m_n   = s_q;
                s_n.v = 1'b0;
            end else if (accept) begin
                m_n = {1'b1, bus.i_d};
            end else begin
                m_n.v = 1'b0;
            end
        end else if (accept) begin
            if (!m_q.v) m_n = {1'b1, bus.i_d};
            else        s_n = {1'b1, bus.i_d};
        end
    end

    // fifo_count lags pushes by one cycle, so this cycle's transfer is added in
    // to keep the bound pessimistic; pops only count once they show up.
    always_ff @(posedge clock) begin
        if (reset) begin
            m_q    <= '0;
            s_q    <= '0;
            ir_q   <= 1'b0;
            gate_q <= 1'b0;
        end else begin
            m_q    <= m_n;
            s_q    <= s_n;
            ir_q   <= ~s_n.v;
            gate_q <= (({1'b0, fifo_count} + (CNT_W+1)'(xfer)) < LIMIT);
        end
    end

`ifdef STREAM_CREDIT_TX_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            beat_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (xfer)     beat_cnt  <= beat_cnt + 32'd1;
            if (throttle) stall_cnt <= stall_cnt + 32'd1;
        end
    end
`else
    assign beat_cnt  = 32'd0;
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_stream_credit_tx.sv
// Scoreboard bench for stream_credit_tx with DEPTH=16, MARGIN=2 (LIMIT=14).
module tb_stream_credit_tx;
    localparam int WIDTH  = 8;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 4;
    localparam int MARGIN = 2;
`ifdef STREAM_CREDIT_TX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [CNT_W-1:0] fc_manual = '0;
    logic [CNT_W-1:0] fifo_count;
    logic             throttle;
    logic [31:0]      beat_cnt;
    logic [31:0]      stall_cnt;
    logic             use_model = 1'b0;
    logic             stab_en = 1'b0;
    int               pushes = 0;
    int               pushes_q = 0;
    int               xfers = 0;
    int               accepts = 0;
    int               n_chk = 0;
    int               n_err = 0;
    logic [WIDTH-1:0] sb[$];
    logic             prev_hold = 1'b0;
    logic [WIDTH-1:0] prev_d = '0;

    stream_credit_tx_if #(.WIDTH(WIDTH)) bus();

    stream_credit_tx #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W), .MARGIN(MARGIN)
    ) dut (
        .clock(clock),
        .reset(reset),
        .fifo_count(fifo_count),
        .bus(bus),
        .throttle(throttle),
        .beat_cnt(beat_cnt),
        .stall_cnt(stall_cnt)
    );

    always #5 clock = ~clock;

    // Never-popping FIFO model: occupancy shows each push from the next cycle on.
    assign fifo_count = use_model ? pushes_q[CNT_W-1:0] : fc_manual;
    always @(posedge clock) pushes_q <= pushes;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Inputs only change just after posedge, so negedge sees what the next edge samples.
    always @(negedge clock) begin
        if (reset) begin
            sb.delete();
            prev_hold = 1'b0;
        end else begin
            if (stab_en && prev_hold) begin
                chk("hold_v", {31'b0, bus.o_v}, 32'd1);
                chk("hold_d", {24'b0, bus.o_d}, {24'b0, prev_d});
            end
            prev_hold = bus.o_v & ~bus.o_r;
            prev_d    = bus.o_d;
            if (bus.o_v && bus.o_r) begin
                xfers++;
                if (use_model) pushes++;
                if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
                else                chk("sb_data", {24'b0, bus.o_d}, {24'b0, sb.pop_front()});
            end
            if (bus.i_v && bus.i_r) begin
                sb.push_back(bus.i_d);
                accepts++;
            end
        end
    end

    initial begin
        int x0, a0;
        logic acc;
        logic [WIDTH-1:0] nd;
        bus.i_v = 1'b0;
        bus.i_d = '0;
        bus.o_r = 1'b0;

        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_ir", {31'b0, bus.i_r}, 32'd0);
            chk("rst_ov", {31'b0, bus.o_v}, 32'd0);
            chk("rst_thr", {31'b0, throttle}, 32'd0);
            chk("rst_beat", beat_cnt, 32'd0);
            chk("rst_stall", stall_cnt, 32'd0);
        end
        reset   = 1'b0;
        bus.o_r = 1'b1;
        tick();
        chk("rel_ir", {31'b0, bus.i_r}, 32'd1);

        // Full-rate stream with 1-cycle latency.
        for (int k = 0; k < 64; k++) begin
            bus.i_v = 1'b1;
            bus.i_d = WIDTH'(k);
            tick();
            chk("stream", {23'b0, bus.o_v, bus.o_d}, {23'b0, 1'b1, 8'(k)});
        end
        bus.i_v = 1'b0;
        tick();
        chk("stream_end_ov", {31'b0, bus.o_v}, 32'd0);
        chk("stream_beat", beat_cnt, STATS ? 32'd64 : 32'd0);
        chk("stream_stall", stall_cnt, 32'd0);

        // FIFO that never pops.
        x0 = xfers;
        a0 = accepts;
        use_model = 1'b1;
        nd = 8'h40;
        for (int j = 0; j < 24; j++) begin
            bus.i_v = 1'b1;
            bus.i_d = nd;
            acc = bus.i_r;
            tick();
            if (acc) nd++;
        end
        chk("np_xfers", xfers - x0, 32'd14);
        chk("np_accepts", accepts - a0, 32'd16);
        chk("np_ov", {31'b0, bus.o_v}, 32'd0);
        chk("np_thr", {31'b0, throttle}, 32'd1);
        chk("np_ir", {31'b0, bus.i_r}, 32'd0);
        chk("np_stall", stall_cnt, STATS ? 32'd9 : 32'd0);

        // Occupancy falls to 10: both held beats drain in order.
        bus.i_v = 1'b0;
        use_model = 1'b0;
        fc_manual = 4'd10;
        tick();
        chk("rel_ov", {31'b0, bus.o_v}, 32'd1);
        chk("rel_d0", {24'b0, bus.o_d}, 32'h4E);
        chk("rel_thr", {31'b0, throttle}, 32'd0);
        tick();
        chk("rel_d1", {23'b0, bus.o_v, bus.o_d}, 32'h14F);
        chk("rel_ir_up", {31'b0, bus.i_r}, 32'd1);
        tick();
        chk("rel_empty_ov", {31'b0, bus.o_v}, 32'd0);
        chk("rel_sb", sb.size(), 32'd0);

        // Random valid/ready.
        fc_manual = 4'd0;
        stab_en = 1'b1;
        x0 = xfers;
        a0 = accepts;
        for (int c = 0; c < 60000 && (accepts - a0) < 10000; c++) begin
            bus.i_v = 1'($urandom_range(1));
            bus.i_d = WIDTH'($urandom);
            bus.o_r = 1'($urandom_range(1));
            tick();
        end
        chk("rnd_budget", {31'b0, (accepts - a0) >= 10000}, 32'd1);
        bus.i_v = 1'b0;
        bus.o_r = 1'b1;
        for (int c = 0; c < 3; c++) tick();
        stab_en = 1'b0;
        chk("rnd_sb", sb.size(), 32'd0);
        chk("rnd_count", xfers - x0, accepts - a0);

        // Reset with both entries occupied.
        bus.o_r = 1'b0;
        bus.i_v = 1'b1;
        bus.i_d = 8'hA0;
        tick();
        bus.i_d = 8'hA1;
        tick();
        bus.i_v = 1'b0;
        tick();
        chk("full_ir", {31'b0, bus.i_r}, 32'd0);
        chk("full_ov", {31'b0, bus.o_v}, 32'd1);
        reset = 1'b1;
        tick();
        chk("mid_rst_ov", {31'b0, bus.o_v}, 32'd0);
        chk("mid_rst_ir", {31'b0, bus.i_r}, 32'd0);
        reset = 1'b0;
        tick();
        chk("mid_rel_ir", {31'b0, bus.i_r}, 32'd1);
        chk("mid_rel_ov", {31'b0, bus.o_v}, 32'd0);
        bus.i_v = 1'b1;
        bus.i_d = 8'hC5;
        bus.o_r = 1'b1;
        tick();
        chk("fresh", {23'b0, bus.o_v, bus.o_d}, 32'h1C5);
        bus.i_v = 1'b0;
        tick();
        chk("fresh_done", {31'b0, bus.o_v}, 32'd0);
        chk("fresh_sb", sb.size(), 32'd0);
        chk("fresh_beat", beat_cnt, STATS ? 32'd1 : 32'd0);
        chk("fresh_stall", stall_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
